// File: rtl/uart_pkg.sv
// Shared definitions for the UART command parser: FSM states, ASCII
// constants and hex conversion helpers.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA_HI,
        DATA_LO,
        WAIT_CR,
        SKIP,
        EXEC,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters A-F and a-f share the same low nibble (1..6), so one offset covers both.
    function automatic logic [3:0] hex2nib(input logic [7:0] c);
        if (c <= 8'h39) begin
            return c[3:0];
        end
        return c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "W" AA DD CR writes a register, "R" AA CR reads one;
// replies "K" CR LF, two hex digits CR LF, or "E" CR LF on a malformed command.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata
);

    localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            rdy_en_q;
    logic            is_wr_q, is_wr_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [3:0][7:0] rsp_q, rsp_d;
    logic [1:0]      len_q, len_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            accept;
    logic            waiting;
    logic            err;
    logic [3:0]      nib;

    assign waiting   = state_q inside {ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_CR, SKIP};
    // rdy_en_q holds rx_ready low until the first clock after reset release.
    assign rx_ready  = rdy_en_q && (waiting || state_q == IDLE);
    assign accept    = rx_valid && rx_ready;
    assign nib       = hex2nib(rx_data);

    assign tx_valid  = (state_q == RESP);
    assign tx_data   = (state_q == RESP) ? rsp_q[idx_q] : '0;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = (state_q == EXEC) && is_wr_q;
    assign reg_rd_en = (state_q == EXEC) && !is_wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rsp_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rsp_q    <= rsp_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((rx_data | 8'h20) == (CH_W | 8'h20)) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR_HI;
                    end else if ((rx_data | 8'h20) == (CH_R | 8'h20)) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR_HI;
                    end else if (rx_data != CR && rx_data != LF) begin
                        state_d = SKIP;
                    end
                end
            end
            ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
                if (accept) begin
                    if (rx_data == CR) begin
                        err = 1'b1;
                    end else if (!is_hex(rx_data)) begin
                        state_d = SKIP;
                    end else begin
                        case (state_q)
                            ADDR_HI: begin
                                addr_d  = {nib, addr_q[3:0]};
                                state_d = ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr_d  = {addr_q[7:4], nib};
                                state_d = is_wr_q ? DATA_HI : WAIT_CR;
                            end
                            DATA_HI: begin
                                wdata_d = {nib, wdata_q[3:0]};
                                state_d = DATA_LO;
                            end
                            default: begin
                                wdata_d = {wdata_q[7:4], nib};
                                state_d = WAIT_CR;
                            end
                        endcase
                    end
                end
            end
            WAIT_CR: begin
                if (accept) begin
                    state_d = (rx_data == CR) ? EXEC : SKIP;
                end
            end
            SKIP: begin
                if (accept && rx_data == CR) begin
                    err = 1'b1;
                end
            end
            EXEC: begin
                idx_d = '0;
                if (is_wr_q) begin
                    rsp_d   = {8'h00, LF, CR, CH_K};
                    len_d   = 2'd2;
                    state_d = RESP;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rsp_d   = {LF, CR, nib2hex(reg_rdata[3:0]), nib2hex(reg_rdata[7:4])};
                len_d   = 2'd3;
                idx_d   = '0;
                state_d = RESP;
            end
            RESP: begin
                if (tx_valid && tx_ready) begin
                    if (idx_q == len_q) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (err) begin
            rsp_d   = {8'h00, LF, CR, CH_E};
            len_d   = 2'd2;
            idx_d   = '0;
            state_d = RESP;
        end

        // Silence inside a command abandons it without a reply.
        if (waiting && !accept) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: writes, reads, errors, backpressure,
// inter-byte timeout and reset behaviour.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;

    int wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0, rise_cyc = 0, excl_bad = 0;
    logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic txv_prev = 1'b0;
    logic [7:0] txq[$];

    uart_cmd_parser #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= reg_addr;
            wr_data <= reg_wdata;
        end
        if (reg_rd_en) begin
            rd_cnt  <= rd_cnt + 1;
            rd_cyc  <= cyc;
            rd_addr <= reg_addr;
        end
        if (reg_wr_en && reg_rd_en) excl_bad <= excl_bad + 1;
        if (tx_valid && !txv_prev) rise_cyc <= cyc;
        txv_prev <= tx_valid;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called right after a posedge (+1); returns right after the accepting posedge (+1).
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1;
                last_acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte: rx_ready never high for byte %h", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txq.size() >= target) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, tx_valid, tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b txv=%b txd=%h addr=%h wd=%h wr=%b rd=%b, want all 0",
                     rx_ready, tx_valid, tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_clock: got %b want 0", rx_ready);
        end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_clock: got %b want 1", rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write;
        logic [7:0] exp[3] = '{8'h4B, 8'h0D, 8'h0A};
        int b = txq.size();
        int w = wr_cnt;
        int r = rd_cnt;
        int acc;
        tx_ready = 1'b1;
        send_str("W3A5C\r");
        acc = last_acc;
        wait_tx(b + 3);
        checks++;
        if (wr_cnt - w !== 1 || rd_cnt !== r || wr_addr !== 8'h3A || wr_data !== 8'h5C) begin
            errors++;
            $display("FAIL write_bus: got wr=%0d rd=%0d addr=%h data=%h, want wr=1 rd=0 addr=3a data=5c",
                     wr_cnt - w, rd_cnt - r, wr_addr, wr_data);
        end
        checks++;
        if (wr_cyc !== acc + 1 || rise_cyc !== acc + 2) begin
            errors++;
            $display("FAIL write_timing: got wr@+%0d txv@+%0d, want +1 and +2", wr_cyc - acc, rise_cyc - acc);
        end
        checks++;
        if (txq.size() !== b + 3) begin
            errors++;
            $display("FAIL write_tx_len: got %0d bytes want 3", txq.size() - b);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (txq[b + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL write_tx[%0d]: got %h want %h", i, txq[b + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_read;
        logic [7:0] exp[4] = '{8'h41, 8'h37, 8'h0D, 8'h0A};
        int b = txq.size();
        int r = rd_cnt;
        int w = wr_cnt;
        int acc;
        reg_rdata = 8'hA7;
        send_str("\nr1f\r");
        acc = last_acc;
        wait_tx(b + 4);
        checks++;
        if (rd_cnt - r !== 1 || wr_cnt !== w || rd_addr !== 8'h1F) begin
            errors++;
            $display("FAIL read_bus: got rd=%0d wr=%0d addr=%h, want rd=1 wr=0 addr=1f",
                     rd_cnt - r, wr_cnt - w, rd_addr);
        end
        checks++;
        if (rd_cyc !== acc + 1 || rise_cyc !== acc + 3) begin
            errors++;
            $display("FAIL read_timing: got rd@+%0d txv@+%0d, want +1 and +3", rd_cyc - acc, rise_cyc - acc);
        end
        checks++;
        if (txq.size() !== b + 4) begin
            errors++;
            $display("FAIL read_tx_len: got %0d bytes want 4", txq.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (txq[b + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL read_tx[%0d]: got %h want %h", i, txq[b + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_case_mix;
        int b = txq.size();
        int w = wr_cnt;
        send_str("wfFE0\r");
        wait_tx(b + 3);
        checks++;
        if (wr_cnt - w !== 1 || wr_addr !== 8'hFF || wr_data !== 8'hE0 || txq.size() !== b + 3 || txq[b] !== 8'h4B) begin
            errors++;
            $display("FAIL case_mix_write: got wr=%0d addr=%h data=%h bytes=%0d, want 1 ff e0 3 starting 4b",
                     wr_cnt - w, wr_addr, wr_data, txq.size() - b);
        end
    endtask

    task automatic test_error;
        logic [7:0] exp[4] = '{8'h33, 8'h43, 8'h0D, 8'h0A};
        int b = txq.size();
        int w = wr_cnt;
        int r = rd_cnt;
        send_str("W3G\r");
        wait_tx(b + 3);
        checks++;
        if (wr_cnt !== w || rd_cnt !== r || txq.size() !== b + 3 ||
            txq[b] !== 8'h45 || txq[b + 1] !== 8'h0D || txq[b + 2] !== 8'h0A) begin
            errors++;
            $display("FAIL bad_hex: got wr=%0d rd=%0d bytes=%0d, want no bus and 45 0d 0a",
                     wr_cnt - w, rd_cnt - r, txq.size() - b);
        end
        b = txq.size();
        reg_rdata = 8'h3C;
        send_str("R00\r");
        wait_tx(b + 4);
        checks++;
        if (rd_cnt - r !== 1 || rd_addr !== 8'h00 || txq.size() !== b + 4) begin
            errors++;
            $display("FAIL after_error_read: got rd=%0d addr=%h bytes=%0d, want 1 00 4",
                     rd_cnt - r, rd_addr, txq.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (txq[b + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL after_error_tx[%0d]: got %h want %h", i, txq[b + i], exp[i]);
                end
            end
        end
        b = txq.size();
        r = rd_cnt;
        send_str("R5\r");
        wait_tx(b + 3);
        checks++;
        if (rd_cnt !== r || txq.size() !== b + 3 || txq[b] !== 8'h45) begin
            errors++;
            $display("FAIL short_cmd: got rd=%0d bytes=%0d, want no bus and E reply", rd_cnt - r, txq.size() - b);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp[4] = '{8'h30, 8'h35, 8'h0D, 8'h0A};
        int b = txq.size();
        int bad = 0;
        bit seen = 0;
        bit lf = 0;
        tx_ready = 1'b0;
        reg_rdata = 8'h05;
        send_str("R7e\r");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_valid: tx_valid never rose, want 1");
        end
        for (int i = 0; i < 10; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h30 || rx_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0 (txv=1 txd=30 rdy=0)", bad);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid && rx_ready) bad++;
            if (tx_valid && tx_data == 8'h0A) begin
                lf = 1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!lf || bad != 0 || rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got lf=%0d overlap=%0d rdy=%b txv=%b, want 1 0 1 0",
                     lf, bad, rx_ready, tx_valid);
        end
        wait_tx(b + 4);
        checks++;
        if (txq.size() !== b + 4) begin
            errors++;
            $display("FAIL bp_tx_len: got %0d bytes want 4", txq.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (txq[b + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_tx[%0d]: got %h want %h", i, txq[b + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int b = txq.size();
        int w = wr_cnt;
        int r = rd_cnt;
        int acc;
        tx_ready = 1'b1;
        // 49 idle cycles followed by a byte on the 50th must keep the command alive.
        send_str("W12");
        acc = last_acc;
        repeat (49) @(posedge clk);
        #1;
        send_byte(8'h33);
        checks++;
        if (last_acc !== acc + 50) begin
            errors++;
            $display("FAIL tmo_edge_accept: accepted at +%0d want +50", last_acc - acc);
        end
        send_str("4\r");
        wait_tx(b + 3);
        checks++;
        if (wr_cnt - w !== 1 || wr_addr !== 8'h12 || wr_data !== 8'h34 || txq.size() !== b + 3 || txq[b] !== 8'h4B) begin
            errors++;
            $display("FAIL tmo_edge_write: got wr=%0d addr=%h data=%h bytes=%0d, want 1 12 34 3",
                     wr_cnt - w, wr_addr, wr_data, txq.size() - b);
        end
        b = txq.size();
        w = wr_cnt;
        send_str("W12");
        repeat (60) @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (txq.size() !== b || wr_cnt !== w) begin
            errors++;
            $display("FAIL tmo_silent: got %0d tx bytes %0d writes, want 0 0", txq.size() - b, wr_cnt - w);
        end
        reg_rdata = 8'h9B;
        send_str("R44\r");
        wait_tx(b + 4);
        checks++;
        if (rd_cnt - r !== 1 || rd_addr !== 8'h44 || txq.size() !== b + 4 || txq[b] !== 8'h39 || txq[b + 1] !== 8'h42) begin
            errors++;
            $display("FAIL tmo_recover: got rd=%0d addr=%h bytes=%0d, want 1 44 4 starting 39 42",
                     rd_cnt - r, rd_addr, txq.size() - b);
        end
    endtask

    task automatic test_reset_mid;
        int b;
        int w;
        bit seen = 0;
        tx_ready = 1'b0;
        send_str("W01\r");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen = 1;
                break;
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!seen || tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_resp: got seen=%0d txv=%b txd=%h rdy=%b, want 1 0 00 0",
                     seen, tx_valid, tx_data, rx_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        b = txq.size();
        w = wr_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (txq.size() !== b || wr_cnt !== w) begin
            errors++;
            $display("FAIL reset_resp_quiet: got %0d bytes %0d writes, want 0 0", txq.size() - b, wr_cnt - w);
        end
        @(posedge clk);
        #1;
        send_str("W55");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_str("AA\r");
        wait_tx(b + 3);
        checks++;
        if (wr_cnt !== w || txq.size() !== b + 3 || txq[b] !== 8'h45) begin
            errors++;
            $display("FAIL reset_mid_cmd: got %0d writes %0d bytes, want 0 writes and E reply",
                     wr_cnt - w, txq.size() - b);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_case_mix();
        test_error();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        checks++;
        if (excl_bad !== 0) begin
            errors++;
            $display("FAIL wr_rd_exclusive: %0d overlapping cycles, want 0", excl_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
